// File: rtl/lab3_mem_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lab3_mem_line_mem_responder
// Purpose  : 16B-line main-memory model that sits beneath a lab3 cache. It
//            accepts one read/write/init request at a time and answers it
//            after a programmable latency.
// Options  : LAB3_MEM_RESP_RANDOM_DELAY_EN adds 0..3 LFSR-chosen extra cycles
//            of latency to each transaction.
// Revision : 1.0  initial release
// ============================================================================
module lab3_mem_line_mem_responder #(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [174:0] cache2mem_reqstream_msg,
    input  logic         cache2mem_reqstream_val,
    output logic         cache2mem_reqstream_rdy,
    output logic [144:0] cache2mem_respstream_msg,
    output logic         cache2mem_respstream_val,
    input  logic         cache2mem_respstream_rdy
);

    localparam int IW = $clog2(p_num_lines);
    localparam int CW = 5;

    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam logic [2:0] TYPE_INIT  = 3'd2;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    mem_req_16B_t  w_req;
    logic [IW-1:0] w_idx;
    logic          w_accept;
    logic          w_is_wr;
    logic [CW-1:0] w_cnt_load;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    mem_resp_16B_t resp_q;
    logic          req_rdy_q;
    logic          resp_val_q;
    logic [127:0]  mem_q [p_num_lines];

    assign w_req    = cache2mem_reqstream_msg;
    assign w_idx    = w_req.addr[4+IW-1:4];
    assign w_is_wr  = (w_req.type_ == TYPE_WRITE) || (w_req.type_ == TYPE_INIT);
    // No transfer can complete while reset is held, so the array stays untouched.
    assign w_accept = reset && cache2mem_reqstream_val && req_rdy_q;

    // Offset bits, upper alias bits and len carry no meaning for a full-line model.
    logic unused_req_bits;
    assign unused_req_bits = ^{w_req.addr[31:4+IW], w_req.addr[3:0], w_req.len};

`ifdef LAB3_MEM_RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_cnt_load = CW'(p_latency) + {{(CW-2){1'b0}}, lfsr_q[1:0]};
`else
    assign w_cnt_load = CW'(p_latency);
`endif

    always_ff @(posedge clk) begin
        if (w_accept && w_is_wr) begin
            mem_q[w_idx] <= w_req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            resp_q     <= '0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        resp_q.type_  <= w_req.type_;
                        resp_q.opaque <= w_req.opaque;
                        resp_q.test   <= 2'd0;
                        resp_q.len    <= 4'd0;
                        resp_q.data   <= (w_req.type_ == TYPE_READ) ? mem_q[w_idx] : 128'd0;
                        cnt_q         <= w_cnt_load;
                        req_rdy_q     <= 1'b0;
                        if (w_cnt_load == '0) begin
                            state_q    <= RESP;
                            resp_val_q <= 1'b1;
                        end else begin
                            state_q    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q    <= RESP;
                        resp_val_q <= 1'b1;
                    end
                end
                RESP: begin
                    // Ready rises only after the response drains: no same-cycle accept.
                    if (cache2mem_respstream_rdy) begin
                        state_q    <= IDLE;
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    resp_val_q <= 1'b0;
                    req_rdy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign cache2mem_reqstream_rdy  = req_rdy_q;
    assign cache2mem_respstream_val = resp_val_q;
    assign cache2mem_respstream_msg = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_lab3_mem_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab3_mem_line_mem_responder
// Purpose  : Directed and randomized checks of the line memory responder
//            against a line-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lab3_mem_line_mem_responder;

    localparam int NL  = 256;
    localparam int LAT = 2;
`ifdef LAB3_MEM_RESP_RANDOM_DELAY_EN
    localparam int XTRA = 3;
`else
    localparam int XTRA = 0;
`endif

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic [174:0] req_msg  = '0;
    logic         req_val  = 1'b0;
    logic         req_rdy;
    logic [144:0] resp_msg;
    logic         resp_val;
    logic         resp_rdy = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] model [NL];

    lab3_mem_line_mem_responder #(
        .p_num_lines (NL),
        .p_latency   (LAT)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .cache2mem_reqstream_msg  (req_msg),
        .cache2mem_reqstream_val  (req_val),
        .cache2mem_reqstream_rdy  (req_rdy),
        .cache2mem_respstream_msg (resp_msg),
        .cache2mem_respstream_val (resp_val),
        .cache2mem_respstream_rdy (resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One complete transaction; hold = cycles to stall the response in RESP.
    task automatic txn(input logic [2:0] ty, input logic [7:0] op, input logic [31:0] addr,
                       input logic [3:0] len, input logic [127:0] data, input int hold);
        int           idx;
        int           lat;
        bit           ok;
        bit           busy_ok;
        logic [144:0] exp_resp;
        logic [144:0] snap;

        idx      = int'((addr / 32'd16) % NL);
        exp_resp = {ty, op, 2'b00, 4'b0000, (ty == 3'd0) ? model[idx] : 128'd0};
        if (ty == 3'd1 || ty == 3'd2) model[idx] = data;

        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_rdy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("req_rdy_idle", ok, 1'b1);

        req_msg = {ty, op, addr, len, data};
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        req_msg = {$urandom(), rand128()};

        lat     = 0;
        busy_ok = 1'b1;
        while (!resp_val && lat < 40) begin
            if (req_rdy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("rdy_low_while_busy", busy_ok, 1'b1);
        check("latency_in_range", (lat >= LAT && lat <= LAT + XTRA), 1'b1);
        check("resp_val_seen", resp_val, 1'b1);

        snap = resp_msg;
        ok   = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!resp_val || req_rdy || resp_msg !== snap) ok = 1'b0;
        end
        if (hold > 0) check("resp_hold_stable", ok, 1'b1);
        check("resp_msg", resp_msg, exp_resp);

        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check("back_to_idle", {resp_val, req_rdy}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pat;
        bit           seen;
        int           r;

        pat = 128'h0123456789ABCDEF0123456789ABCDEF;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {req_rdy, resp_val, resp_msg}, {1'b1, 1'b0, 145'd0});
        reset = 1'b1;

        // write then read back, with a 5-cycle response stall on the read
        txn(3'd1, 8'h05, 32'h0000_1000, 4'd0, pat, 0);
        txn(3'd0, 8'h06, 32'h0000_1000, 4'd0, 128'd0, 5);

        // reset while waiting drops the response but keeps the write
        @(posedge clk); #1;
        req_msg = {3'd1, 8'h33, 32'h0000_0040, 4'd0, 128'hAA};
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        model[4] = 128'hAA;
        check("busy_after_accept", req_rdy, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("mid_reset_state", {req_rdy, resp_val, resp_msg}, {1'b1, 1'b0, 145'd0});
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (resp_val) seen = 1'b1;
        end
        check("dropped_resp_silent", seen, 1'b0);
        txn(3'd0, 8'h34, 32'h0000_0040, 4'd0, 128'd0, 0);

        // aliasing, offset bits ignored, nonzero len and unknown type
        pat = rand128();
        txn(3'd1, 8'h10, 32'h0000_0010, 4'd0, pat, 1);
        txn(3'd0, 8'h11, 32'h0000_1010, 4'd0, 128'd0, 0);
        txn(3'd0, 8'h12, 32'h0000_001C, 4'd7, 128'd0, 2);
        txn(3'd5, 8'h13, 32'hFFFF_F01F, 4'd0, rand128(), 0);
        txn(3'd0, 8'h14, 32'h0000_0010, 4'd0, 128'd0, 0);
        txn(3'd2, 8'h15, 32'hABCD_E0F3, 4'd3, rand128(), 0);
        txn(3'd0, 8'h16, 32'h0000_00F0, 4'd0, 128'd0, 0);

        // randomized traffic over a small line pool with random alias bits
        for (int i = 0; i < 16; i++) begin
            txn(3'd2, 8'($urandom()), ($urandom() & 32'hFFFF_F00F) | 32'(i << 4),
                4'($urandom()), rand128(), 0);
        end
        for (int i = 0; i < 100; i++) begin
            logic [2:0]  ty;
            logic [31:0] a;
            r  = $urandom_range(0, 9);
            ty = (r < 5) ? 3'd0 : (r < 8) ? 3'd1 : (r == 8) ? 3'd2 : 3'($urandom_range(3, 7));
            a  = ($urandom() & 32'hFFFF_F00F) | 32'($urandom_range(0, 15) << 4);
            txn(ty, 8'($urandom()), a, 4'($urandom()), rand128(), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
